// File: rtl/ov7670_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_pkg
// Shared types and defaults for the OV7670-compatible stream generator.
//   pattern_e : pixel source selector (memory or one of three test patterns)
//   state_e   : frame sequencer states
//   DEF_*     : default VGA timing used when the top is not overridden
//   hiByte    : builds the first byte of an RGB444 pixel pair
// ---------------------------------------------------------------------------
package ov7670_pkg;

   typedef enum logic [1:0] {
      MEM   = 2'd0,
      BARS  = 2'd1,
      GRAD  = 2'd2,
      WHITE = 2'd3
   } pattern_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VSYNC  = 3'd1,
      BACK   = 3'd2,
      ACTIVE = 3'd3,
      FRONT  = 3'd4
   } state_e;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_H_BLANK  = 288;
   localparam int DEF_VS_LINES = 3;
   localparam int DEF_V_BACK   = 17;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_AW       = 19;

   // The camera sends red alone in the low nibble of the first byte.
   function automatic logic [7:0] hiByte(input logic [11:0] rgb);
      return {4'h0, rgb[11:8]};
   endfunction

endpackage

// File: rtl/ov7670_pattern.sv
// ---------------------------------------------------------------------------
// ov7670_pattern
// Combinational pixel source. Picks between framebuffer data and the
// built-in test patterns for the pixel at column i_x.
//   i_x      : pixel column within the active line
//   i_sel    : pixel source
//   i_rdData : framebuffer word {R,G,B}
//   o_rgb    : resulting 12-bit {R,G,B}
// ---------------------------------------------------------------------------
module ov7670_pattern
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int XW       = 10
) (
   input  logic [XW-1:0] i_x,
   input  pattern_e      i_sel,
   input  logic [11:0]   i_rdData,
   output logic [11:0]   o_rgb
);

   logic [2:0] w_bar;
   logic [3:0] w_grad;

   // Bar index and gradient level are x scaled into 8 and 16 steps across
   // the line; H_ACTIVE is a constant so the divide folds away.
   always_comb begin
      w_bar  = 3'((32'(i_x) * 32'd8) / 32'(H_ACTIVE));
      w_grad = 4'((32'(i_x) * 32'd16) / 32'(H_ACTIVE));
      case (i_sel)
         MEM:     o_rgb = i_rdData;
         BARS:    o_rgb = {{4{w_bar[2]}}, {4{w_bar[1]}}, {4{w_bar[0]}}};
         GRAD:    o_rgb = {w_grad, w_grad, w_grad};
         default: o_rgb = 12'hFFF;
      endcase
   end

endmodule

// File: rtl/ov7670_stream_gen.sv
// ---------------------------------------------------------------------------
// ov7670_stream_gen
// OV7670-style RGB444 pixel stream transmitter (two bytes per pixel, one
// byte per clock) fed from a framebuffer read port or a test pattern.
//   clk_50      : only clock
//   reset       : asynchronous active-high reset
//   enable      : start/continue frames, looked at only between frames
//   pattern_sel : 0 memory, 1 bars, 2 gradient, 3 white
//   rd_en       : framebuffer read strobe (memory mode only)
//   rd_addr     : framebuffer address y*H_ACTIVE+x
//   rd_data     : framebuffer word, valid one cycle after rd_en
//   vsync       : frame sync, high for VS_LINES lines
//   href        : high during active bytes
//   d           : pixel byte, zero outside href
//   frame_start : pulse on the first vsync cycle
//   frame_done  : pulse on the last cycle of the front porch
//   busy        : high from frame start through frame_done
// ---------------------------------------------------------------------------
module ov7670_stream_gen
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int H_BLANK  = DEF_H_BLANK,
   parameter int VS_LINES = DEF_VS_LINES,
   parameter int V_BACK   = DEF_V_BACK,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int AW       = DEF_AW
) (
   input  logic          clk_50,
   input  logic          reset,
   input  logic          enable,
   input  logic [1:0]    pattern_sel,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [11:0]   rd_data,
   output logic          vsync,
   output logic          href,
   output logic [7:0]    d,
   output logic          frame_start,
   output logic          frame_done,
   output logic          busy
);

   localparam int LINE_LEN   = 2 * H_ACTIVE + H_BLANK;
   localparam int LINE_TOTAL = VS_LINES + V_BACK + V_ACTIVE + V_FRONT;
   localparam int CW         = $clog2(LINE_LEN);
   localparam int LW         = $clog2(LINE_TOTAL + 1);
   localparam int XW         = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int PIX_LAST   = H_ACTIVE * V_ACTIVE - 1;

   state_e        r_state;
   logic [CW-1:0] r_col;
   logic [LW-1:0] r_line;
   logic [AW-1:0] r_addr;
   pattern_e      r_pat;

   logic          w_lineEnd;
   logic          w_frameEnd;
   logic          w_pixSlot;

   logic          r1Vs, r1Href, r1Byte1, r1Fs, r1Fd, r1Busy;
   logic [XW-1:0] r1X;
   logic [11:0]   w_rgb;
   logic [7:0]    r_hold;

   // Counter decodes: even columns inside the active part of an ACTIVE
   // line are the pixel slots where a framebuffer read is issued.
   always_comb begin
      w_lineEnd  = (r_col == CW'(LINE_LEN - 1));
      w_frameEnd = w_lineEnd && (r_line == LW'(LINE_TOTAL - 1));
      w_pixSlot  = (r_state == ACTIVE) && (r_col < CW'(2 * H_ACTIVE)) && !r_col[0];
   end

   assign rd_en   = w_pixSlot && (r_pat == MEM);
   assign rd_addr = r_addr;

   // Frame sequencer. col walks every line, line walks the frame, and the
   // state changes on the line boundaries. The address counter advances
   // once per pixel slot and saturates on the last pixel; it is cleared
   // whenever a frame starts or the sequencer goes idle so nothing stale
   // is left on rd_addr. enable and pattern_sel are only looked at when a
   // new frame is about to begin, which keeps frames whole.
   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_col   <= '0;
         r_line  <= '0;
         r_addr  <= '0;
         r_pat   <= MEM;
      end else begin
         if (w_pixSlot && (r_addr != AW'(PIX_LAST)))
            r_addr <= r_addr + 1'b1;
         case (r_state)
            IDLE: begin
               r_col  <= '0;
               r_line <= '0;
               if (enable) begin
                  r_state <= VSYNC;
                  r_addr  <= '0;
                  r_pat   <= pattern_e'(pattern_sel);
               end
            end
            default: begin
               if (w_lineEnd) begin
                  r_col <= '0;
                  if (w_frameEnd) begin
                     r_line <= '0;
                     r_addr <= '0;
                     if (enable) begin
                        r_state <= VSYNC;
                        r_pat   <= pattern_e'(pattern_sel);
                     end else begin
                        r_state <= IDLE;
                     end
                  end else begin
                     r_line <= r_line + 1'b1;
                     if (r_line == LW'(VS_LINES - 1))
                        r_state <= BACK;
                     else if (r_line == LW'(VS_LINES + V_BACK - 1))
                        r_state <= ACTIVE;
                     else if (r_line == LW'(VS_LINES + V_BACK + V_ACTIVE - 1))
                        r_state <= FRONT;
                  end
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
         endcase
      end
   end

   // First pipeline stage: delays the counter decodes by one cycle so they
   // line up with rd_data, which arrives one cycle after the read strobe.
   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         r1Vs    <= 1'b0;
         r1Href  <= 1'b0;
         r1Byte1 <= 1'b0;
         r1Fs    <= 1'b0;
         r1Fd    <= 1'b0;
         r1Busy  <= 1'b0;
         r1X     <= '0;
      end else begin
         r1Vs    <= (r_state == VSYNC);
         r1Href  <= (r_state == ACTIVE) && (r_col < CW'(2 * H_ACTIVE));
         r1Byte1 <= r_col[0];
         r1Fs    <= (r_state == VSYNC) && (r_line == '0) && (r_col == '0);
         r1Fd    <= (r_state == FRONT) && w_frameEnd;
         r1Busy  <= (r_state != IDLE);
         r1X     <= XW'(r_col >> 1);
      end
   end

   ov7670_pattern #(
      .H_ACTIVE (H_ACTIVE),
      .XW       (XW)
   ) u_pattern (
      .i_x      (r1X),
      .i_sel    (r_pat),
      .i_rdData (rd_data),
      .o_rgb    (w_rgb)
   );

   // Output stage: every camera-side output is a flop two cycles behind the
   // counters. The first byte of a pixel goes out straight from the pixel
   // source while its green/blue half is parked in r_hold for the next byte.
   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         vsync       <= 1'b0;
         href        <= 1'b0;
         d           <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         r_hold      <= '0;
      end else begin
         vsync       <= r1Vs;
         href        <= r1Href;
         frame_start <= r1Fs;
         frame_done  <= r1Fd;
         busy        <= r1Busy;
         if (!r1Href) begin
            d <= '0;
         end else if (!r1Byte1) begin
            d      <= hiByte(w_rgb);
            r_hold <= w_rgb[7:0];
         end else begin
            d <= r_hold;
         end
      end
   end

endmodule
